// File: rtl/xrv1_sim_ram_dport.sv
// Data-side adapter between the core load/store channel and port 1 of the simulation RAM.
// Accepts byte/half/word accesses at any byte address. An access that crosses a 32-bit word
// boundary is split into two RAM word accesses. Load data is sign- or zero-extended, and each
// request gets exactly one registered response pulse.
//
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   req_valid_i/req_ready_o request handshake
//   req_addr_i/we/size/unsigned/wdata  request fields
//   rsp_valid_o/rsp_rdata_o one-cycle response pulse with extended load data (0 for stores)
//   ram_addr_o/ram_w_en_o/ram_w_data_o/ram_w_be_o  RAM port 1 drive (word-aligned address)
//   ram_r_data_i            RAM port 1 read data, one cycle after the address
module xrv1_sim_ram_dport #(
  parameter int unsigned addr_width_p = 16
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [31:0]             req_addr_i,
  input  logic                    req_we_i,
  input  logic [1:0]              req_size_i,
  input  logic                    req_unsigned_i,
  input  logic [31:0]             req_wdata_i,
  output logic                    rsp_valid_o,
  output logic [31:0]             rsp_rdata_o,
  output logic [addr_width_p-1:0] ram_addr_o,
  output logic                    ram_w_en_o,
  output logic [31:0]             ram_w_data_o,
  output logic [3:0]              ram_w_be_o,
  input  logic [31:0]             ram_r_data_i
);

  typedef enum logic [2:0] {StIdle, StRdWait, StRdHi, StRdFin, StWrHi} state_e;

  state_e                  state_q, state_d;
  logic [addr_width_p-1:0] addr_q, addr_d;
  logic [1:0]              size_q, size_d;
  logic                    uns_q, uns_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             lo_q, lo_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [31:0]             rsp_rdata_q, rsp_rdata_d;

  // Address bits above the RAM width are ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr_i[31:addr_width_p];

  // In idle the live request is decoded; in every other state the held copy is.
  logic                    idle;
  logic [addr_width_p-1:0] cur_addr;
  logic [1:0]              cur_size;
  logic                    cur_uns;
  logic [31:0]             cur_wdata;

  assign idle      = (state_q == StIdle);
  assign cur_addr  = idle ? req_addr_i[addr_width_p-1:0] : addr_q;
  assign cur_size  = idle ? req_size_i : size_q;
  assign cur_uns   = idle ? req_unsigned_i : uns_q;
  assign cur_wdata = idle ? req_wdata_i : wdata_q;

  logic [1:0]              off;
  logic [2:0]              nbytes;
  logic                    split;
  logic [7:0]              mask_n;
  logic [31:0]             wmask;
  logic [7:0]              m8;
  logic [63:0]             d64;
  logic [addr_width_p-1:0] word0, word1;

  assign off   = cur_addr[1:0];
  assign word0 = {cur_addr[addr_width_p-1:2], 2'b00};
  assign word1 = word0 + addr_width_p'(4);  // wraps from the top word to 0

  always_comb begin
    unique case (cur_size)
      2'd0:    begin nbytes = 3'd1; mask_n = 8'h01; wmask = 32'h0000_00FF; end
      2'd1:    begin nbytes = 3'd2; mask_n = 8'h03; wmask = 32'h0000_FFFF; end
      default: begin nbytes = 3'd4; mask_n = 8'h0F; wmask = 32'hFFFF_FFFF; end
    endcase
  end

  assign split = (({1'b0, off} + nbytes) > 3'd4);
  assign m8    = mask_n << off;
  assign d64   = {32'b0, cur_wdata & wmask} << {off, 3'b000};

  function automatic logic [31:0] extract(input logic [63:0] hl, input logic [1:0] o,
                                          input logic [1:0] sz, input logic u);
    logic [63:0] sh;
    sh = hl >> {o, 3'b000};
    unique case (sz)
      2'd0:    extract = u ? {24'b0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      2'd1:    extract = u ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: extract = sh[31:0];
    endcase
  endfunction

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    size_d       = size_q;
    uns_d        = uns_q;
    wdata_d      = wdata_q;
    lo_d         = lo_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = 32'b0;
    req_ready_o  = 1'b0;
    ram_addr_o   = word0;
    ram_w_en_o   = 1'b0;
    ram_w_be_o   = 4'b0;
    ram_w_data_o = 32'b0;

    unique case (state_q)
      StIdle: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          addr_d  = req_addr_i[addr_width_p-1:0];
          size_d  = req_size_i;
          uns_d   = req_unsigned_i;
          wdata_d = req_wdata_i;
          if (req_we_i) begin
            ram_w_en_o   = 1'b1;
            ram_w_be_o   = m8[3:0];
            ram_w_data_o = d64[31:0];
            if (split) state_d = StWrHi;
            else       rsp_valid_d = 1'b1;
          end else begin
            state_d = split ? StRdHi : StRdWait;
          end
        end
      end
      StWrHi: begin
        ram_addr_o   = word1;
        ram_w_en_o   = 1'b1;
        ram_w_be_o   = m8[7:4];
        ram_w_data_o = d64[63:32];
        rsp_valid_d  = 1'b1;
        state_d      = StIdle;
      end
      StRdWait: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = extract({32'b0, ram_r_data_i}, off, cur_size, cur_uns);
        state_d     = StIdle;
      end
      StRdHi: begin
        ram_addr_o = word1;
        lo_d       = ram_r_data_i;
        state_d    = StRdFin;
      end
      StRdFin: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = extract({ram_r_data_i, lo_q}, off, cur_size, cur_uns);
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Reset blocks acceptance and any RAM write, including a pending high part.
    if (reset_i) begin
      req_ready_o = 1'b0;
      ram_w_en_o  = 1'b0;
      ram_w_be_o  = 4'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      size_q      <= 2'b0;
      uns_q       <= 1'b0;
      wdata_q     <= 32'b0;
      lo_q        <= 32'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      wdata_q     <= wdata_d;
      lo_q        <= lo_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_xrv1_sim_ram_dport.sv
module tb_xrv1_sim_ram_dport;

  localparam int unsigned AW = 16;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic [31:0]   req_addr_i = '0;
  logic          req_we_i = 1'b0;
  logic [1:0]    req_size_i = '0;
  logic          req_unsigned_i = 1'b0;
  logic [31:0]   req_wdata_i = '0;
  logic          rsp_valid_o;
  logic [31:0]   rsp_rdata_o;
  logic [AW-1:0] ram_addr_o;
  logic          ram_w_en_o;
  logic [31:0]   ram_w_data_o;
  logic [3:0]    ram_w_be_o;
  logic [31:0]   ram_r_data_i = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  xrv1_sim_ram_dport #(.addr_width_p(AW)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_we_i(req_we_i), .req_size_i(req_size_i),
    .req_unsigned_i(req_unsigned_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
    .ram_addr_o(ram_addr_o), .ram_w_en_o(ram_w_en_o), .ram_w_data_o(ram_w_data_o),
    .ram_w_be_o(ram_w_be_o), .ram_r_data_i(ram_r_data_i)
  );

  // Simulation RAM port 1: registered read of the old contents, byte-enabled write.
  logic [31:0] ram [0:(1<<(AW-2))-1];
  initial for (int i = 0; i < (1 << (AW - 2)); i++) ram[i] = '0;
  always @(posedge clk) begin
    ram_r_data_i <= ram[ram_addr_o[AW-1:2]];
    if (ram_w_en_o)
      for (int b = 0; b < 4; b++)
        if (ram_w_be_o[b]) ram[ram_addr_o[AW-1:2]][8*b+:8] = ram_w_data_o[8*b+:8];
  end

  // Reference model: flat byte memory, little-endian, address modulo 2^AW.
  logic [7:0] ref_mem [0:(1<<AW)-1];
  initial for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '0;

  function automatic int size_bytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic int ref_lat(input logic [31:0] a, input logic we, input logic [1:0] sz);
    bit crosses;
    crosses = (int'(a[1:0]) + size_bytes(sz)) > 4;
    if (we) return crosses ? 2 : 1;
    return crosses ? 3 : 2;
  endfunction

  function automatic void ref_store(input logic [31:0] a, input logic [1:0] sz,
                                    input logic [31:0] wd);
    for (int i = 0; i < size_bytes(sz); i++) ref_mem[16'(a + 32'(i))] = wd[8*i+:8];
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz,
                                           input logic uns);
    int n;
    logic [31:0] v;
    n = size_bytes(sz);
    v = '0;
    for (int i = 0; i < n; i++) v[8*i+:8] = ref_mem[16'(a + 32'(i))];
    if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Issue one request (called just after a rising edge) and follow it to its response.
  task automatic do_req(input logic [31:0] a, input logic we, input logic [1:0] sz,
                        input logic uns, input logic [31:0] wd,
                        output logic [31:0] rd, output int lat,
                        output logic [15:0] a0, output logic [3:0] be0,
                        output logic [31:0] wd0, output logic we0,
                        output logic [15:0] a1, output logic [3:0] be1,
                        output logic [31:0] wd1, output logic we1,
                        output int rdy_bad, output logic rdy0);
    req_valid_i = 1'b1; req_addr_i = a; req_we_i = we; req_size_i = sz;
    req_unsigned_i = uns; req_wdata_i = wd;
    rd = 'x; lat = -1; rdy_bad = 0;
    a1 = 'x; be1 = 'x; wd1 = 'x; we1 = 'x;
    @(negedge clk);
    a0 = ram_addr_o; be0 = ram_w_be_o; wd0 = ram_w_data_o; we0 = ram_w_en_o;
    rdy0 = req_ready_o;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin
        a1 = ram_addr_o; be1 = ram_w_be_o; wd1 = ram_w_data_o; we1 = ram_w_en_o;
      end
      if (rsp_valid_o) begin
        lat = c; rd = rsp_rdata_o;
        break;
      end
      if (req_ready_o) rdy_bad++;
      @(posedge clk); #1;
    end
    if (lat >= 0) begin
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    logic [31:0] addr;  logic we;  logic [1:0] size;  logic uns;  logic [31:0] wdata;
    logic [31:0] exp_rd;  int exp_lat;
    logic [15:0] exp_a0;  logic [3:0] exp_be0;  logic [31:0] exp_wd0;
    logic [15:0] exp_a1;  logic [3:0] exp_be1;  logic [31:0] exp_wd1;
  } vec_t;

  vec_t vecs [12];

  initial begin
    logic [31:0] rd, wd0, wd1;
    logic [15:0] a0, a1;
    logic [3:0]  be0, be1;
    logic        we0, we1, rdy0;
    int          lat, rdy_bad;
    bit          sp;

    //          addr          we  sz  u  wdata          exp_rd        lat a0       be0   wd0           a1       be1   wd1
    vecs[0]  = '{32'h0000_0100, 1, 2, 0, 32'hDEADBEEF, 32'h0,        1, 16'h0100, 4'hF, 32'hDEADBEEF, 16'h0, 4'h0, 32'h0};
    vecs[1]  = '{32'h0000_0100, 0, 2, 0, 32'h0,        32'hDEADBEEF, 2, 16'h0100, 4'h0, 32'h0,        16'h0, 4'h0, 32'h0};
    vecs[2]  = '{32'h0000_0103, 1, 0, 0, 32'h0000_0080, 32'h0,       1, 16'h0100, 4'h8, 32'h8000_0000, 16'h0, 4'h0, 32'h0};
    vecs[3]  = '{32'h0000_0103, 0, 0, 0, 32'h0,        32'hFFFFFF80, 2, 16'h0100, 4'h0, 32'h0,        16'h0, 4'h0, 32'h0};
    vecs[4]  = '{32'h0000_0103, 0, 0, 1, 32'h0,        32'h00000080, 2, 16'h0100, 4'h0, 32'h0,        16'h0, 4'h0, 32'h0};
    vecs[5]  = '{32'h0000_0102, 1, 2, 0, 32'h11223344, 32'h0,        2, 16'h0100, 4'hC, 32'h3344_0000, 16'h0104, 4'h3, 32'h0000_1122};
    vecs[6]  = '{32'h0000_0102, 0, 2, 0, 32'h0,        32'h11223344, 3, 16'h0100, 4'h0, 32'h0,        16'h0104, 4'h0, 32'h0};
    vecs[7]  = '{32'h0000_FFFF, 1, 0, 0, 32'h0000_00AB, 32'h0,       1, 16'hFFFC, 4'h8, 32'hAB00_0000, 16'h0, 4'h0, 32'h0};
    vecs[8]  = '{32'hABCD_0000, 1, 0, 0, 32'h0000_00CD, 32'h0,       1, 16'h0000, 4'h1, 32'h0000_00CD, 16'h0, 4'h0, 32'h0};
    vecs[9]  = '{32'h0000_FFFF, 0, 1, 0, 32'h0,        32'hFFFFCDAB, 3, 16'hFFFC, 4'h0, 32'h0,        16'h0000, 4'h0, 32'h0};
    vecs[10] = '{32'h0000_0101, 0, 1, 1, 32'h0,        32'h000044BE, 2, 16'h0100, 4'h0, 32'h0,        16'h0, 4'h0, 32'h0};
    vecs[11] = '{32'h0000_0105, 0, 0, 0, 32'h0,        32'h00000011, 2, 16'h0104, 4'h0, 32'h0,        16'h0, 4'h0, 32'h0};

    // Reset behaviour.
    repeat (3) begin
      @(negedge clk);
      chk("reset ready", 32'(req_ready_o), 32'h0);
      chk("reset w_en", 32'(ram_w_en_o), 32'h0);
    end
    @(posedge clk); #1;
    reset_i = 1'b0;
    @(negedge clk);
    chk("post-reset ready", 32'(req_ready_o), 32'h1);
    chk("post-reset rsp_valid", 32'(rsp_valid_o), 32'h0);
    chk("post-reset rsp_rdata", rsp_rdata_o, 32'h0);
    @(posedge clk); #1;

    // Directed table.
    for (int i = 0; i < 12; i++) begin
      do_req(vecs[i].addr, vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].wdata,
             rd, lat, a0, be0, wd0, we0, a1, be1, wd1, we1, rdy_bad, rdy0);
      if (vecs[i].we) ref_store(vecs[i].addr, vecs[i].size, vecs[i].wdata);
      sp = vecs[i].we ? (vecs[i].exp_lat == 2) : (vecs[i].exp_lat == 3);
      chk($sformatf("vec%0d ready", i), 32'(rdy0), 32'h1);
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d addr0", i), 32'(a0), 32'(vecs[i].exp_a0));
      chk($sformatf("vec%0d w_en0", i), 32'(we0), 32'(vecs[i].we));
      chk($sformatf("vec%0d be0", i), 32'(be0), 32'(vecs[i].exp_be0));
      chk($sformatf("vec%0d busy ready", i), 32'(rdy_bad), 32'h0);
      if (vecs[i].we) chk($sformatf("vec%0d wdata0", i), wd0, vecs[i].exp_wd0);
      if (sp) begin
        chk($sformatf("vec%0d addr1", i), 32'(a1), 32'(vecs[i].exp_a1));
        chk($sformatf("vec%0d w_en1", i), 32'(we1), 32'(vecs[i].we));
        chk($sformatf("vec%0d be1", i), 32'(be1), 32'(vecs[i].exp_be1));
        if (vecs[i].we) chk($sformatf("vec%0d wdata1", i), wd1, vecs[i].exp_wd1);
      end
    end

    // Reset while the high part of a split store is pending.
    req_valid_i = 1'b1; req_addr_i = 32'h0302; req_we_i = 1'b1; req_size_i = 2'd2;
    req_unsigned_i = 1'b0; req_wdata_i = 32'h55667788;
    @(negedge clk);
    chk("rst-split addr0", 32'(ram_addr_o), 32'h0300);
    chk("rst-split be0", 32'(ram_w_be_o), 32'hC);
    @(posedge clk); #1;
    req_valid_i = 1'b0; reset_i = 1'b1;
    @(negedge clk);
    chk("rst-split w_en in WR_HI", 32'(ram_w_en_o), 32'h0);
    chk("rst-split ready in reset", 32'(req_ready_o), 32'h0);
    @(posedge clk); #1;
    reset_i = 1'b0;
    @(negedge clk);
    chk("rst-split ready after", 32'(req_ready_o), 32'h1);
    chk("rst-split no rsp", 32'(rsp_valid_o), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst-split no rsp later", 32'(rsp_valid_o), 32'h0);
    @(posedge clk); #1;
    ref_mem[16'h0302] = 8'h88;
    ref_mem[16'h0303] = 8'h77;
    do_req(32'h0304, 1'b0, 2'd2, 1'b0, 32'h0, rd, lat, a0, be0, wd0, we0, a1, be1, wd1, we1,
           rdy_bad, rdy0);
    chk("rst-split high word", rd, 32'h0000_0000);
    do_req(32'h0300, 1'b0, 2'd2, 1'b0, 32'h0, rd, lat, a0, be0, wd0, we0, a1, be1, wd1, we1,
           rdy_bad, rdy0);
    chk("rst-split low word", rd, 32'h7788_0000);

    // Back-to-back aligned stores, one per cycle.
    for (int i = 0; i < 8; i++) begin
      req_valid_i = 1'b1; req_addr_i = 32'h0200 + 32'(4 * i); req_we_i = 1'b1;
      req_size_i = 2'd2; req_wdata_i = 32'hA5A5_0000 + 32'(i);
      ref_store(req_addr_i, 2'd2, req_wdata_i);
      @(negedge clk);
      chk($sformatf("b2b%0d w_en", i), 32'(ram_w_en_o), 32'h1);
      chk($sformatf("b2b%0d addr", i), 32'(ram_addr_o), 32'h0200 + 32'(4 * i));
      chk($sformatf("b2b%0d ready", i), 32'(req_ready_o), 32'h1);
      if (i > 0) chk($sformatf("b2b%0d rsp", i), 32'(rsp_valid_o), 32'h1);
      @(posedge clk); #1;
    end
    req_valid_i = 1'b0;
    @(negedge clk);
    chk("b2b last rsp", 32'(rsp_valid_o), 32'h1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b rsp ends", 32'(rsp_valid_o), 32'h0);
    @(posedge clk); #1;
    do_req(32'h021C, 1'b0, 2'd2, 1'b0, 32'h0, rd, lat, a0, be0, wd0, we0, a1, be1, wd1, we1,
           rdy_bad, rdy0);
    chk("b2b readback", rd, ref_load(32'h021C, 2'd2, 1'b0));

    // Randomized traffic against the byte-memory model.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a, wd, exp;
      logic        we, uns;
      logic [1:0]  sz;
      logic [15:0] a16;
      a16 = ($urandom_range(0, 1) == 0) ? 16'(16'h0400 + $urandom_range(0, 63))
                                        : 16'(16'hFFF8 + $urandom_range(0, 15));
      a   = {16'($urandom), a16};
      we  = 1'($urandom);
      sz  = 2'($urandom);
      uns = 1'($urandom);
      wd  = $urandom;
      exp = we ? 32'h0 : ref_load(a, sz, uns);
      do_req(a, we, sz, uns, wd, rd, lat, a0, be0, wd0, we0, a1, be1, wd1, we1,
             rdy_bad, rdy0);
      if (we) ref_store(a, sz, wd);
      chk($sformatf("rnd%0d lat a=%08h we=%0d sz=%0d", i, a, we, sz), 32'(lat),
          32'(ref_lat(a, we, sz)));
      chk($sformatf("rnd%0d rdata a=%08h we=%0d sz=%0d u=%0d", i, a, we, sz, uns), rd, exp);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/xrv1_sim_ram_dport.md
Name: xrv1_sim_ram_dport

Overview:
- Data-side adapter between the core's load/store request channel and port 1 (read/write port) of the simulation RAM.
- Accepts byte, halfword and word accesses at any byte address and splits accesses that cross a 32-bit word boundary into two RAM word accesses.
- Drives word-aligned address, byte-enables and lane-shifted write data to the RAM.
- Extracts and sign- or zero-extends read data, and returns one registered response pulse per request.

Parameters:
- addr_width_p, 16: RAM byte-address width; must match the RAM's address width.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- reset_i  in  1  synchronous, active-high reset.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  adapter can accept a request this cycle.
- req_addr_i  in  32  byte address; bits above addr_width_p-1 are ignored.
- req_we_i  in  1  1 = store, 0 = load.
- req_size_i  in  2  access size: 0 = byte, 1 = half, 2 = word; 3 is treated as word.
- req_unsigned_i  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_wdata_i  in  32  store data, right-justified.
- rsp_valid_o  out  1  one-cycle response pulse; there is no backpressure.
- rsp_rdata_o  out  32  extended load data; 0 for stores.
- ram_addr_o  out  addr_width_p  RAM port 1 address; bits [1:0] are always 0.
- ram_w_en_o  out  1  RAM write enable.
- ram_w_data_o  out  32  RAM write data, lane-aligned.
- ram_w_be_o  out  4  RAM byte enables.
- ram_r_data_i  in  32  RAM port 1 read data; valid one cycle after its address was presented.

Behaviour:
Derived quantities:
- off = addr[1:0]; n = 1 << size (n = 4 when size = 3).
- split = (off + n > 4).
- word0 = {addr[addr_width_p-1:2], 2'b00}.
- word1 = word0 + 4, modulo 2^addr_width_p (wraps from the top word to 0).
- Store mask: m8 = ((1<<n)-1) << off. Shifted data: d64 = {32'b0, wdata masked to n bytes} << (8*off).
- Low part is m8[3:0] / d64[31:0]; high part is m8[7:4] / d64[63:32].

States: IDLE, RD_WAIT, RD_HI, RD_FIN, WR_HI.

RAM port drive (combinational from state and the accepted or held request):
- ram_w_en_o = 0 and ram_w_be_o = 0 whenever no store part is being issued.
- ram_w_en_o is forced to 0 during reset.

IDLE:
- req_ready_o = 1.
- On req_valid_i: drive ram_addr_o = word0 and latch the request into holding registers.
- Store, not split: issue the low part. Next state IDLE; rsp_valid_o = 1 next cycle.
- Store, split: issue the low part. Next state WR_HI.
- Load, not split: next state RD_WAIT.
- Load, split: next state RD_HI.

WR_HI:
- Drive word1 with the high part, ram_w_en_o = 1.
- Next state IDLE; rsp_valid_o = 1 next cycle.

RD_WAIT:
- ram_r_data_i is word0.
- Register the extracted result into rsp_rdata_o and pulse rsp_valid_o next cycle. Next state IDLE.

RD_HI:
- Drive ram_addr_o = word1; capture ram_r_data_i (word0) into lo_q. Next state RD_FIN.

RD_FIN:
- ram_r_data_i is word1.
- Extract from {ram_r_data_i, lo_q}. Register the result and pulse rsp_valid_o next cycle. Next state IDLE.

req_ready_o:
- 0 in every state other than IDLE.
- A new request is accepted in the same cycle that rsp_valid_o is high, so back-to-back aligned stores complete one per cycle.

Extraction:
- r = {hi, lo} >> (8*off); keep the low n bytes.
- Sign-extend from bit 8n-1 unless req_unsigned_i; n = 4 passes through unchanged.

Latency, counted from the accept cycle (cycle 0), to the cycle rsp_valid_o is high:
- aligned store: cycle 1.
- split store: cycle 2.
- aligned load: cycle 2.
- split load: cycle 3.

Reset:
- State goes to IDLE; rsp_valid_o = 0; rsp_rdata_o = 0; lo_q = 0.
- req_ready_o = 0 while reset_i is high.
- Reset mid-access abandons the access: no high-part write is issued afterwards and no response is produced.
- If reset arrives after the low part of a split store, that low part stays written.

Test Plan:
- Aligned word store 0xDEADBEEF @0x100, then word load @0x100 -> be = 4'hF at addr 0x100, rsp_valid_o in cycle 1; load response 0xDEADBEEF in cycle 2.
- Byte store 0x80 @0x103, then signed byte load @0x103 and unsigned byte load @0x103 -> be = 4'b1000, w_data[31:24] = 0x80; signed result 0xFFFFFF80, unsigned result 0x00000080.
- Split word store 0x11223344 @0x102 -> cycle 0: addr 0x100, be 4'b1100, data 0x33440000; cycle 1: addr 0x104, be 4'b0011, data 0x00001122; rsp_valid_o in cycle 2. A word load @0x102 then returns 0x11223344 in cycle 3, with req_ready_o low in cycles 1–2.
- Signed half load @0xFFFF (addr_width_p = 16), with 0xFFFC holding 0xAB000000 and 0x0000 holding 0x000000CD -> second access drives addr 0x0000 (wrap); result 0xFFFFCDAB.
- Reset asserted in WR_HI of a split store -> ram_w_en_o = 0 that cycle, no rsp_valid_o pulse, req_ready_o = 1 the cycle after reset deasserts; the word at the high address is unchanged.
- Aligned store accepted every cycle for 8 cycles to 0x200..0x21C -> 8 RAM writes on consecutive cycles and 8 consecutive rsp_valid_o pulses.
